// File: rtl/sevenseg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_pkg
// Description : Shared constants, state type and helpers for the seven-segment
//               capture block. Segment patterns are active-low and written
//               MSB-first as {g,f,e,d,c,b,a}.
// Revision    : 1.0 - initial release
// ============================================================================
package sevenseg_pkg;

    // Active-low segment patterns, bit 0 = a ... bit 6 = g
    localparam logic [6:0] SEG_0          = 7'b1000000;
    localparam logic [6:0] SEG_1          = 7'b1111001;
    localparam logic [6:0] SEG_2          = 7'b0100100;
    localparam logic [6:0] SEG_3          = 7'b0110000;
    localparam logic [6:0] SEG_4          = 7'b0011001;
    localparam logic [6:0] SEG_5          = 7'b0010010;
    localparam logic [6:0] SEG_6          = 7'b0000010;
    localparam logic [6:0] SEG_7          = 7'b1111000;
    localparam logic [6:0] SEG_8          = 7'b0000000;
    localparam logic [6:0] SEG_9          = 7'b0010000;
    localparam logic [6:0] SEG_UNDERSCORE = 7'b1110111;
    localparam logic [6:0] SEG_BLANK      = 7'b1111111;

    // Digit codes beyond 0..9
    localparam logic [3:0] CODE_UNDERSCORE = 4'd10;
    localparam logic [3:0] CODE_INVALID    = 4'd14;
    localparam logic [3:0] CODE_BLANK      = 4'd15;

    // Anode patterns (active-low, one digit selected)
    localparam logic [3:0] AN_SLOT0 = 4'b1110;
    localparam logic [3:0] AN_SLOT1 = 4'b1101;
    localparam logic [3:0] AN_SLOT2 = 4'b1011;
    localparam logic [3:0] AN_SLOT3 = 4'b0111;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        COLLECT = 2'd1,
        STALLED = 2'd2
    } state_t;

    // True when exactly one anode is driven low
    function automatic logic an_single_low(input logic [3:0] an);
        return ($countones(~an) == 1);
    endfunction

    // Slot index of the selected digit; only meaningful when an_single_low()
    function automatic logic [1:0] an_slot(input logic [3:0] an);
        logic [1:0] slot;
        case (an)
            AN_SLOT1: slot = 2'd1;
            AN_SLOT2: slot = 2'd2;
            AN_SLOT3: slot = 2'd3;
            default:  slot = 2'd0;
        endcase
        return slot;
    endfunction

    // All four codes are decimal digits
    function automatic logic digits_decimal(input logic [15:0] d);
        return (d[3:0] <= 4'd9) && (d[7:4] <= 4'd9) &&
               (d[11:8] <= 4'd9) && (d[15:12] <= 4'd9);
    endfunction

    // d3*1000 + d2*100 + d1*10 + d0; 9999 fits in 14 bits
    function automatic logic [13:0] digits_to_value(input logic [15:0] d);
        return (14'(d[15:12]) * 14'd1000) + (14'(d[11:8]) * 14'd100) +
               (14'(d[7:4]) * 14'd10) + 14'(d[3:0]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sevenseg_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_capture_if
// Description : Bundle of the tapped display bus (an/seg) and the captured
//               frame results. master = display side / consumer,
//               slave = capture block.
// Revision    : 1.0 - initial release
// ============================================================================
interface sevenseg_capture_if;
    logic [3:0]  an;           // anode enables, active-low
    logic [6:0]  seg;          // segment lines, active-low
    logic [15:0] digits;       // captured codes, 4 bits per digit
    logic [13:0] value;        // binary value, 0 when !value_ok
    logic        value_ok;     // all codes decimal
    logic        frame_valid;  // one-cycle frame update pulse
    logic        seg_err;      // last frame had an undecodable pattern
    logic        stalled;      // scanning timed out
    logic [15:0] frame_count;  // frames emitted, wrapping

    modport master (
        output an, seg,
        input  digits, value, value_ok, frame_valid, seg_err, stalled, frame_count
    );

    modport slave (
        input  an, seg,
        output digits, value, value_ok, frame_valid, seg_err, stalled, frame_count
    );
endinterface
`default_nettype wire

// File: rtl/sevenseg_capture_seg_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg_decode
// Description : Combinational active-low seven-segment pattern to digit code.
//               Unknown patterns map to CODE_INVALID with o_invalid set.
// Ports       : i_seg     - active-low segments {g..a}
//               o_code    - 4-bit digit code
//               o_invalid - pattern not recognised
// Revision    : 1.0 - initial release
// ============================================================================
module seg_decode
    import sevenseg_pkg::*;
(
    input  wire logic [6:0] i_seg,
    output logic      [3:0] o_code,
    output logic            o_invalid
);

    always_comb begin
        o_code    = CODE_INVALID;
        o_invalid = 1'b0;
        case (i_seg)
            SEG_0:          o_code = 4'd0;
            SEG_1:          o_code = 4'd1;
            SEG_2:          o_code = 4'd2;
            SEG_3:          o_code = 4'd3;
            SEG_4:          o_code = 4'd4;
            SEG_5:          o_code = 4'd5;
            SEG_6:          o_code = 4'd6;
            SEG_7:          o_code = 4'd7;
            SEG_8:          o_code = 4'd8;
            SEG_9:          o_code = 4'd9;
            SEG_UNDERSCORE: o_code = CODE_UNDERSCORE;
            SEG_BLANK:      o_code = CODE_BLANK;
            default:        o_invalid = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sevenseg_capture.sv
`default_nettype none
// ============================================================================
// Module      : sevenseg_capture
// Description : Taps a multiplexed 4-digit seven-segment bus, debounces each
//               {an,seg} sample, reassembles one frame per scan and reports
//               digit codes, binary value and error/stall status.
// Ports       : clk   - system clock (display driver clock)
//               reset - synchronous, active-high
//               cap   - sevenseg_capture_if.slave (an/seg in, frame results out)
// Revision    : 1.0 - initial release
// ============================================================================
module sevenseg_capture
    import sevenseg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 2,     // 1..15
    parameter int TIMEOUT_CYCLES = 1024
)(
    input  wire logic          clk,
    input  wire logic          reset,
    sevenseg_capture_if.slave  cap
);

    // Run counter saturates one past the accept length so the accept
    // condition holds for exactly one cycle per run.
    localparam int              RUN_W      = 5;
    localparam logic [RUN_W-1:0] RUN_ACCEPT = RUN_W'(STABLE_CYCLES);
    localparam logic [RUN_W-1:0] RUN_SAT    = RUN_W'(STABLE_CYCLES + 1);
    localparam int              TO_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------
    // Sampling and run-length debounce
    // ------------------------------------------------------------------
    logic [3:0]       r_samp_an;
    logic [6:0]       r_samp_seg;
    logic [RUN_W-1:0] r_run;
    logic             w_same;

    assign w_same = ({cap.an, cap.seg} == {r_samp_an, r_samp_seg});

    always_ff @(posedge clk) begin
        if (reset) begin
            r_samp_an  <= 4'hF;
            r_samp_seg <= SEG_BLANK;
            r_run      <= RUN_W'(1);
        end else begin
            r_samp_an  <= cap.an;
            r_samp_seg <= cap.seg;
            if (!w_same)
                r_run <= RUN_W'(1);
            else if (r_run != RUN_SAT)
                r_run <= r_run + RUN_W'(1);
        end
    end

    logic [3:0] w_code;
    logic       w_invalid;
    logic       w_accept;
    logic [1:0] w_slot;
    logic [3:0] w_slot_bit;

    seg_decode u_seg_decode (
        .i_seg     (r_samp_seg),
        .o_code    (w_code),
        .o_invalid (w_invalid)
    );

    assign w_accept   = (r_run == RUN_ACCEPT) && an_single_low(r_samp_an);
    assign w_slot     = an_slot(r_samp_an);
    assign w_slot_bit = 4'b0001 << w_slot;

    // ------------------------------------------------------------------
    // Inactivity timeout; any accept restarts it
    // ------------------------------------------------------------------
    logic [TO_W-1:0] r_to_cnt;
    logic            w_to_hit;

    always_ff @(posedge clk) begin
        if (reset || w_accept)
            r_to_cnt <= '0;
        else if (r_to_cnt != TO_LAST)
            r_to_cnt <= r_to_cnt + TO_W'(1);
    end

    assign w_to_hit = (r_to_cnt == TO_LAST) && !w_accept;

    // ------------------------------------------------------------------
    // Frame assembly FSM
    // ------------------------------------------------------------------
    state_t      r_state, w_state_nxt;
    logic [3:0]  r_mask,  w_mask_nxt;
    logic        r_err,   w_err_nxt;
    logic        w_store;
    logic        w_complete;
    logic [15:0] r_slots;
    logic [15:0] w_merged;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SYNC;
            r_mask  <= 4'b0000;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_err_nxt   = r_err;
        w_store     = 1'b0;
        w_complete  = 1'b0;
        w_merged    = r_slots;
        w_merged[{w_slot, 2'b00} +: 4] = w_code;

        case (r_state)
            SYNC, STALLED: begin
                if (w_accept && (w_slot == 2'd0)) begin
                    w_store     = 1'b1;
                    w_mask_nxt  = 4'b0001;
                    w_err_nxt   = w_invalid;
                    w_state_nxt = COLLECT;
                end else if ((r_state == SYNC) && w_to_hit) begin
                    w_mask_nxt  = 4'b0000;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = STALLED;
                end
            end
            COLLECT: begin
                if (w_accept) begin
                    w_store = 1'b1;
                    if ((r_mask | w_slot_bit) == 4'b1111) begin
                        w_complete  = 1'b1;
                        w_mask_nxt  = 4'b0000;
                        w_err_nxt   = 1'b0;
                        w_state_nxt = SYNC;
                    end else begin
                        w_mask_nxt = r_mask | w_slot_bit;
                        w_err_nxt  = r_err | w_invalid;
                    end
                end else if (w_to_hit) begin
                    w_mask_nxt  = 4'b0000;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = STALLED;
                end
            end
            default: begin
                w_mask_nxt  = 4'b0000;
                w_err_nxt   = 1'b0;
                w_state_nxt = SYNC;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Slot storage and frame staging. The completed frame is snapshotted
    // so the slot registers are free for the next scan immediately.
    // ------------------------------------------------------------------
    logic        r_complete;
    logic [15:0] r_stage_digits;
    logic        r_stage_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_slots        <= 16'hFFFF;
            r_complete     <= 1'b0;
            r_stage_digits <= 16'hFFFF;
            r_stage_err    <= 1'b0;
        end else begin
            r_complete <= w_complete;
            if (w_store)
                r_slots <= w_merged;
            if (w_complete) begin
                r_stage_digits <= w_merged;
                r_stage_err    <= r_err | w_invalid;
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame outputs
    // ------------------------------------------------------------------
    logic [15:0] r_digits;
    logic [13:0] r_value;
    logic        r_value_ok;
    logic        r_frame_valid;
    logic        r_seg_err;
    logic [15:0] r_frame_count;
    logic        w_stage_ok;

    assign w_stage_ok = digits_decimal(r_stage_digits);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_digits      <= 16'hFFFF;
            r_value       <= '0;
            r_value_ok    <= 1'b0;
            r_frame_valid <= 1'b0;
            r_seg_err     <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_frame_valid <= r_complete;
            if (r_complete) begin
                r_digits      <= r_stage_digits;
                r_value_ok    <= w_stage_ok;
                r_value       <= w_stage_ok ? digits_to_value(r_stage_digits) : '0;
                r_seg_err     <= r_stage_err;
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    assign cap.digits      = r_digits;
    assign cap.value       = r_value;
    assign cap.value_ok    = r_value_ok;
    assign cap.frame_valid = r_frame_valid;
    assign cap.seg_err     = r_seg_err;
    assign cap.stalled     = (r_state == STALLED);
    assign cap.frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_sevenseg_capture
// Description : Directed self-checking bench for sevenseg_capture. Expected
//               frames are queued as each scan is driven and compared when
//               frame_valid pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sevenseg_capture;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    sevenseg_capture_if cap ();

    sevenseg_capture #(
        .STABLE_CYCLES  (2),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .cap   (cap)
    );

    typedef struct {
        logic [15:0] digits;
        logic [13:0] value;
        logic        ok;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          passed = 0;
    int          failed = 0;
    int          total  = 0;
    logic [15:0] exp_count = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] pat(input int c);
        case (c)
            0:  return 7'b1000000;
            1:  return 7'b1111001;
            2:  return 7'b0100100;
            3:  return 7'b0110000;
            4:  return 7'b0011001;
            5:  return 7'b0010010;
            6:  return 7'b0000010;
            7:  return 7'b1111000;
            8:  return 7'b0000000;
            9:  return 7'b0010000;
            10: return 7'b1110111;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [3:0] an_of(input int k);
        logic [3:0] a;
        a    = 4'hF;
        a[k] = 1'b0;
        return a;
    endfunction

    task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
        cap.an  = a;
        cap.seg = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                        input logic [6:0] p2, input logic [6:0] p3);
        drive(an_of(0), p0, 2);
        drive(an_of(1), p1, 2);
        drive(an_of(2), p2, 2);
        drive(an_of(3), p3, 2);
    endtask

    task automatic push(input logic [15:0] d, input logic [13:0] v,
                        input logic ok, input logic err);
        exp_t x;
        exp_count = exp_count + 16'd1;
        x.digits  = d;
        x.value   = v;
        x.ok      = ok;
        x.err     = err;
        x.cnt     = exp_count;
        sb.push_back(x);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_digits"},   cap.digits,      16'hFFFF);
        check({tag, "_value"},    cap.value,       14'd0);
        check({tag, "_ok"},       cap.value_ok,    1'b0);
        check({tag, "_fvalid"},   cap.frame_valid, 1'b0);
        check({tag, "_segerr"},   cap.seg_err,     1'b0);
        check({tag, "_stalled"},  cap.stalled,     1'b0);
        check({tag, "_fcount"},   cap.frame_count, 16'd0);
    endtask

    // Scoreboard consumer
    always @(negedge clk) begin
        if (reset === 1'b0 && cap.frame_valid === 1'b1) begin
            check("frame_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("digits",      cap.digits,      e.digits);
                check("value",       cap.value,       e.value);
                check("value_ok",    cap.value_ok,    e.ok);
                check("seg_err",     cap.seg_err,     e.err);
                check("frame_count", cap.frame_count, e.cnt);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        cap.an  = 4'hF;
        cap.seg = 7'h7F;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset("rst");

        // Repeated clean scans of 1234
        for (int n = 0; n < 3; n++) begin
            push(16'h1234, 14'd1234, 1'b1, 1'b0);
            scan(pat(4), pat(3), pat(2), pat(1));
        end
        drain("drain_1234");

        // Distance style: 5, underscore, 2, 1
        push(16'h12A5, 14'd0, 1'b0, 1'b0);
        scan(pat(5), pat(10), pat(2), pat(1));
        drain("drain_dist");

        // One-cycle transient between slot 0 and slot 1 is not accepted
        push(16'h1234, 14'd1234, 1'b1, 1'b0);
        drive(an_of(0), pat(4), 2);
        drive(4'b1011, pat(8), 1);
        drive(an_of(1), pat(3), 2);
        drive(an_of(2), pat(2), 2);
        drive(an_of(3), pat(1), 2);
        drain("drain_transient");

        // Undecodable pattern in slot 2, then a clean frame clears seg_err
        push(16'h1E34, 14'd0, 1'b0, 1'b1);
        scan(pat(4), pat(3), 7'b0101010, pat(1));
        push(16'h1234, 14'd1234, 1'b1, 1'b0);
        scan(pat(4), pat(3), pat(2), pat(1));
        drain("drain_segerr");

        // Scanning stops: stall after the timeout, outputs hold
        drive(4'hF, 7'h7F, 1000);
        check("stall_not_early", cap.stalled, 1'b0);
        for (int i = 0; i < 200 && cap.stalled !== 1'b1; i++) @(negedge clk);
        check("stalled",      cap.stalled, 1'b1);
        check("stall_digits", cap.digits,  16'h1234);
        check("stall_value",  cap.value,   14'd1234);

        // Resume: stalled drops at the slot 0 accept
        push(16'h1234, 14'd1234, 1'b1, 1'b0);
        drive(an_of(0), pat(4), 2);
        check("stall_before_accept", cap.stalled, 1'b1);
        drive(an_of(1), pat(3), 1);
        check("stall_cleared", cap.stalled, 1'b0);
        @(negedge clk);
        drive(an_of(2), pat(2), 2);
        drive(an_of(3), pat(1), 2);
        drain("drain_resume");

        // Reset mid-frame after slots 0 and 1 have been accepted
        drive(an_of(0), pat(9), 2);
        drive(an_of(1), pat(9), 3);
        reset   = 1'b1;
        cap.an  = 4'hF;
        cap.seg = 7'h7F;
        repeat (2) @(negedge clk);
        reset     = 1'b0;
        exp_count = '0;
        check_reset("midrst");
        // Slots 2 and 3 alone must not complete a frame
        drive(an_of(2), pat(9), 2);
        drive(an_of(3), pat(9), 4);
        check("no_partial_frame", cap.frame_count, 16'd0);
        push(16'h9999, 14'd9999, 1'b1, 1'b0);
        scan(pat(9), pat(9), pat(9), pat(9));
        drain("drain_9999");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
